// File: rtl/adc_if_pkg.sv
// Shared types and helpers for the ADC capture path: sample width default,
// lane-index width and the serialiser state encoding.
package adc_if_pkg;

  localparam int ADC_DATA_W = 8;

  typedef enum logic [0:0] {
    SER_IDLE = 1'b0,
    SER_PUSH = 1'b1
  } ser_state_e;

  // A single lane still needs a 1-bit index field on the stream.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Show-ahead synchronous FIFO holding {lane index, sample} words; the head is
// visible combinationally and reads as zero while the FIFO is empty.
module adc_sample_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         pop_en;
  logic         wr_en;

  // Extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level  = wr_ptr - rd_ptr;
  assign pop_en = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en  = push && (!full || pop_en);
  assign head   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/adc_capture_fifo.sv
// ADC interface: divides clock into adc_clock, snapshots all lanes on each
// adc_clock fall, serialises enabled lanes into a FIFO, sticky overflow flag.
module adc_capture_fifo
  import adc_if_pkg::*;
#(
  parameter int  DATA_W = ADC_DATA_W,
  parameter int  NUM_CH = 2,
  parameter int  DEPTH  = 16,
  parameter int  DIV_W  = 8,
  localparam int CH_W   = ch_idx_w(NUM_CH),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     cfg_en,
  input  logic [DIV_W-1:0]         cfg_div,
  input  logic [NUM_CH-1:0]        cfg_ch_mask,
  output logic                     adc_clock,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [LVL_W-1:0]         level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output ser_state_e               dbg_ser_state
);

  // Stream handshake: a word transfers on every rising clock edge where
  // out_valid and out_ready are both 1; out_valid never waits on out_ready.

  logic [DIV_W-1:0]         div_cnt;
  logic [DIV_W-1:0]         div_q;
  logic                     snap_edge;
  logic                     mask_any;
  ser_state_e               ser_state;
  logic [NUM_CH*DATA_W-1:0] snap_data;
  logic [NUM_CH-1:0]        rem_mask;
  logic [NUM_CH-1:0]        rem_rest;
  logic [CH_W-1:0]          sel;
  logic [DATA_W-1:0]        lane_word;
  logic                     push_q;
  logic [DATA_W-1:0]        push_data_q;
  logic [CH_W-1:0]          push_ch_q;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     snap_drop;
  logic                     fifo_drop;
  logic [CH_W+DATA_W-1:0]   head;

  // Half-period length is latched at each toggle (and while idle) so a
  // mid-period cfg_div change only affects the next half-period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      div_q     <= '0;
      adc_clock <= 1'b0;
    end else if (!cfg_en) begin
      div_cnt   <= '0;
      div_q     <= cfg_div;
      adc_clock <= 1'b0;
    end else if (div_cnt == div_q) begin
      div_cnt   <= '0;
      div_q     <= cfg_div;
      adc_clock <= ~adc_clock;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  assign snap_edge = cfg_en && (div_cnt == div_q) && adc_clock;
  assign mask_any  = (cfg_ch_mask != '0);

  // Lowest pending lane goes next; rem_rest is the mask with it removed.
  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rem_mask[i]) sel = CH_W'(i);
    end
  end

  assign rem_rest  = rem_mask & (rem_mask - NUM_CH'(1));
  assign lane_word = snap_data[sel*DATA_W +: DATA_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ser_state   <= SER_IDLE;
      snap_data   <= '0;
      rem_mask    <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_ch_q   <= '0;
    end else begin
      push_q <= 1'b0;
      if (!cfg_en) begin
        ser_state <= SER_IDLE;
        rem_mask  <= '0;
      end else begin
        case (ser_state)
          SER_IDLE: begin
            if (snap_edge && mask_any) begin
              snap_data <= adc_data;
              rem_mask  <= cfg_ch_mask;
              ser_state <= SER_PUSH;
            end
          end
          SER_PUSH: begin
            push_q      <= 1'b1;
            push_data_q <= lane_word;
            push_ch_q   <= sel;
            if (rem_rest != '0) begin
              rem_mask <= rem_rest;
            end else if (snap_edge && mask_any) begin
              // Last lane leaves this cycle, so the new snapshot hands over.
              snap_data <= adc_data;
              rem_mask  <= cfg_ch_mask;
            end else begin
              rem_mask  <= '0;
              ser_state <= SER_IDLE;
            end
          end
          default: ser_state <= SER_IDLE;
        endcase
      end
    end
  end

  assign dbg_ser_state = ser_state;

  assign snap_drop = snap_edge && mask_any && (ser_state == SER_PUSH) && (rem_rest != '0);
  assign fifo_drop = push_q && fifo_full && !pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (snap_drop || fifo_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = head[DATA_W-1:0];
  assign out_ch    = head[CH_W+DATA_W-1:DATA_W];

  adc_sample_fifo #(
    .W     (CH_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_q),
    .push_data ({push_ch_q, push_data_q}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (level)
  );

endmodule

// File: tb/tb_adc_capture_fifo.sv
// Directed bench for adc_capture_fifo: a 2-lane instance for divider, stream,
// mask, fill/overflow and reset cases, and a 4-lane instance for snapshot overrun.
module tb_adc_capture_fifo;
  import adc_if_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // 2-lane instance
  logic        cfg_en, out_ready, ovf_clr;
  logic [7:0]  cfg_div;
  logic [1:0]  cfg_ch_mask;
  logic [15:0] adc_data;
  logic        adc_clock, out_valid, overflow;
  logic [7:0]  out_data;
  logic [0:0]  out_ch;
  logic [4:0]  level;
  ser_state_e  dbg_ser_state;

  // 4-lane instance
  logic        cfg_en4, out_ready4, ovf_clr4;
  logic [7:0]  cfg_div4;
  logic [3:0]  mask4;
  logic [31:0] adc_data4;
  logic        adc_clock4, out_valid4, overflow4;
  logic [7:0]  out_data4;
  logic [1:0]  out_ch4;
  logic [4:0]  level4;
  ser_state_e  dbg4;

  int n_checks = 0;
  int n_pass   = 0;

  adc_capture_fifo #(.DATA_W(8), .NUM_CH(2), .DEPTH(16), .DIV_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_en(cfg_en), .cfg_div(cfg_div),
    .cfg_ch_mask(cfg_ch_mask), .adc_clock(adc_clock), .adc_data(adc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .level(level), .overflow(overflow), .ovf_clr(ovf_clr),
    .dbg_ser_state(dbg_ser_state)
  );

  adc_capture_fifo #(.DATA_W(8), .NUM_CH(4), .DEPTH(16), .DIV_W(8)) dut4 (
    .clock(clock), .reset_n(reset_n), .cfg_en(cfg_en4), .cfg_div(cfg_div4),
    .cfg_ch_mask(mask4), .adc_clock(adc_clock4), .adc_data(adc_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_ch(out_ch4), .level(level4), .overflow(overflow4), .ovf_clr(ovf_clr4),
    .dbg_ser_state(dbg4)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  // Returns at the negedge just after adc_clock fell (the snapshot edge).
  task automatic wait_fall();
    logic prev;
    bit   seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      prev = adc_clock;
      @(negedge clock);
      if (prev === 1'b1 && adc_clock === 1'b0) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL wait_fall: no adc_clock fall within 200 cycles");
    end
  endtask

  task automatic drain_all();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && level !== 5'd0; i++) @(negedge clock);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; cfg_en = 1'b0; cfg_div = 8'd3; cfg_ch_mask = 2'b00;
    adc_data = 16'h0; out_ready = 1'b0; ovf_clr = 1'b0;
    cfg_en4 = 1'b0; cfg_div4 = 8'd0; mask4 = 4'h0; adc_data4 = 32'h0;
    out_ready4 = 1'b0; ovf_clr4 = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (adc_clock !== 1'b0) $display("FAIL reset_adc_clock: got %b want 0", adc_clock); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data); else n_pass++;
    n_checks++; if (out_ch !== 1'b0) $display("FAIL reset_out_ch: got %h want 0", out_ch); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (dbg_ser_state !== SER_IDLE) $display("FAIL reset_ser_state: got %0d want 0", dbg_ser_state); else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++; if (adc_clock !== 1'b0) $display("FAIL disabled_adc_clock: got %b want 0", adc_clock); else n_pass++;
  endtask

  task automatic test_stream();
    logic prev;
    bit   seen;
    int   cyc;
    cfg_ch_mask = 2'b11; adc_data = {8'h3C, 8'hA5}; out_ready = 1'b1; cfg_en = 1'b1;
    wait_fall();
    cyc = 0; seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      prev = adc_clock;
      @(negedge clock);
      cyc++;
      if (prev === 1'b1 && adc_clock === 1'b0) seen = 1;
    end
    n_checks++; if (cyc != 8) $display("FAIL stream_period: got %0d want 8", cyc); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_valid_at_snap: got %b want 0", out_valid); else n_pass++;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_valid_lat1: got %b want 0", out_valid); else n_pass++;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL stream_valid_lat2: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'hA5 || out_ch !== 1'b0) $display("FAIL stream_first: got %h/ch%0d want a5/ch0", out_data, out_ch); else n_pass++;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 1'b1) $display("FAIL stream_second: got v%b %h/ch%0d want v1 3c/ch1", out_valid, out_data, out_ch); else n_pass++;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_idle_after: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL stream_level: got %0d want 0", level); else n_pass++;
  endtask

  task automatic test_mask();
    logic prev;
    int   n_valid, n_falls;
    cfg_ch_mask = 2'b10;
    wait_fall();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mask10_valid0: got %b want 0", out_valid); else n_pass++;
    repeat (2) @(negedge clock);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 1'b1) $display("FAIL mask10_sample: got v%b %h/ch%0d want v1 3c/ch1", out_valid, out_data, out_ch); else n_pass++;
    @(negedge clock);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mask10_single: got %b want 0", out_valid); else n_pass++;
    cfg_ch_mask = 2'b00;
    wait_fall();
    n_valid = 0; n_falls = 0;
    for (int i = 0; i < 80; i++) begin
      prev = adc_clock;
      @(negedge clock);
      if (out_valid === 1'b1) n_valid++;
      if (prev === 1'b1 && adc_clock === 1'b0) n_falls++;
    end
    n_checks++; if (n_valid != 0) $display("FAIL mask0_valid_cycles: got %0d want 0", n_valid); else n_pass++;
    n_checks++; if (n_falls != 10) $display("FAIL mask0_periods: got %0d want 10", n_falls); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL mask0_overflow: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_fill_overflow();
    int         got;
    logic [7:0] exp_d;
    logic [0:0] exp_c;
    cfg_en = 1'b0; cfg_ch_mask = 2'b11; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    cfg_en = 1'b1;
    repeat (8) wait_fall();
    repeat (4) @(negedge clock);
    n_checks++; if (level !== 5'd16) $display("FAIL fill_level16: got %0d want 16", level); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL fill_no_ovf_yet: got %b want 0", overflow); else n_pass++;
    wait_fall();
    repeat (4) @(negedge clock);
    n_checks++; if (overflow !== 1'b1) $display("FAIL fill_overflow: got %b want 1", overflow); else n_pass++;
    n_checks++; if (level !== 5'd16) $display("FAIL fill_level_stays: got %0d want 16", level); else n_pass++;
    cfg_en = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < 16; i++) begin
      if (out_valid === 1'b1) begin
        exp_d = (got % 2 == 0) ? 8'hA5 : 8'h3C;
        exp_c = 1'(got % 2);
        n_checks++; if (out_data !== exp_d || out_ch !== exp_c) $display("FAIL drain_sample%0d: got %h/ch%0d want %h/ch%0d", got, out_data, out_ch, exp_d, exp_c); else n_pass++;
        got++;
      end
      @(negedge clock);
    end
    n_checks++; if (got != 16) $display("FAIL drain_count: got %0d want 16", got); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || level !== 5'd0) $display("FAIL drain_empty: got v%b lvl%0d want v0 lvl0", out_valid, level); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
    out_ready = 1'b0; ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_full_pop_push();
    out_ready = 1'b0; cfg_en = 1'b1;
    repeat (8) wait_fall();
    wait_fall();
    n_checks++; if (level !== 5'd16) $display("FAIL full_before: got %0d want 16", level); else n_pass++;
    @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    n_checks++; if (level !== 5'd16) $display("FAIL full_pushpop1: got %0d want 16", level); else n_pass++;
    @(negedge clock);
    out_ready = 1'b0;
    n_checks++; if (level !== 5'd16) $display("FAIL full_pushpop2: got %0d want 16", level); else n_pass++;
    n_checks++; if (out_data !== 8'hA5 || out_ch !== 1'b0) $display("FAIL full_head: got %h/ch%0d want a5/ch0", out_data, out_ch); else n_pass++;
    @(negedge clock);
    n_checks++; if (overflow !== 1'b0) $display("FAIL full_pushpop_ovf: got %b want 0", overflow); else n_pass++;
    cfg_en = 1'b0;
    drain_all();
    n_checks++; if (level !== 5'd0) $display("FAIL full_drain: got %0d want 0", level); else n_pass++;
  endtask

  task automatic test_ch4_overflow();
    logic prev;
    bit   seen;
    int   got;
    mask4 = 4'hF; adc_data4 = {8'h44, 8'h33, 8'h22, 8'h11}; out_ready4 = 1'b1; cfg_en4 = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      prev = adc_clock4;
      @(negedge clock);
      if (prev === 1'b1 && adc_clock4 === 1'b0) seen = 1;
    end
    n_checks++; if (!seen) $display("FAIL ch4_first_snap: no adc_clock fall got 0 want 1"); else n_pass++;
    n_checks++; if (overflow4 !== 1'b0) $display("FAIL ch4_ovf_snap1: got %b want 0", overflow4); else n_pass++;
    @(negedge clock);
    n_checks++; if (overflow4 !== 1'b0) $display("FAIL ch4_ovf_pre: got %b want 0", overflow4); else n_pass++;
    @(negedge clock);
    n_checks++; if (overflow4 !== 1'b1) $display("FAIL ch4_ovf_snap2: got %b want 1", overflow4); else n_pass++;
    got = 0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      if (out_valid4 === 1'b1) begin
        n_checks++;
        if (out_data4 !== 8'(8'h11 * (got + 1)) || out_ch4 !== 2'(got))
          $display("FAIL ch4_sample%0d: got %h/ch%0d want %h/ch%0d", got, out_data4, out_ch4, 8'(8'h11 * (got + 1)), got);
        else n_pass++;
        got++;
      end
      @(negedge clock);
    end
    n_checks++; if (got != 4) $display("FAIL ch4_count: got %0d want 4", got); else n_pass++;
    cfg_en4 = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_abort_reset();
    bit seen;
    out_ready = 1'b0; cfg_ch_mask = 2'b11; cfg_en = 1'b1;
    repeat (2) wait_fall();
    wait_fall();
    n_checks++; if (level !== 5'd4) $display("FAIL abort_level4: got %0d want 4", level); else n_pass++;
    @(negedge clock);
    cfg_en = 1'b0;
    @(negedge clock);
    n_checks++; if (level !== 5'd5) $display("FAIL abort_level5: got %0d want 5", level); else n_pass++;
    @(negedge clock);
    n_checks++; if (level !== 5'd5) $display("FAIL abort_lane_discarded: got %0d want 5", level); else n_pass++;
    n_checks++; if (adc_clock !== 1'b0) $display("FAIL abort_adc_low: got %b want 0", adc_clock); else n_pass++;
    cfg_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (adc_clock === 1'b1) seen = 1;
    end
    n_checks++; if (!seen) $display("FAIL abort_reenable: adc_clock got 0 want 1"); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (adc_clock !== 1'b0) $display("FAIL midreset_adc_clock: got %b want 0", adc_clock); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL midreset_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid: got %b want 0", out_valid); else n_pass++;
    cfg_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mask();
    test_fill_overflow();
    test_full_pop_push();
    test_ch4_overflow();
    test_abort_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
